// File: rtl/vendor_pkg.sv
// Shared types and constants for the vending-machine customer and its peers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vendor_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PULSE = 3'd1,
        S_GAP   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } vc_state_t;

    // Coin values and item price, all in half-unit steps.
    localparam int COIN_X_HALVES = 1;
    localparam int COIN_Y_HALVES = 2;
    localparam int PRICE_HALVES  = 3;

    function automatic int vc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vendor_customer_if.sv
// Bundle of request, vendor-side coin/strobe and completion signals.
// Latency: n/a (wiring only).
// Backpressure: request side is valid/ready; completion is a one-cycle pulse with no ready.
// Modports: slave = the customer block, master = whatever drives requests and plays vendor.
interface vendor_customer_if;

    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_x_cnt;
    logic [2:0] req_y_cnt;
    logic       outz;
    logic       outo;
    logic       inx;
    logic       iny;
    logic       done_valid;
    logic       done_vend;
    logic       done_change;
    logic       done_timeout;
    logic [3:0] done_coins;

    modport slave (
        input  req_valid, req_x_cnt, req_y_cnt, outz, outo,
        output req_ready, inx, iny,
        output done_valid, done_vend, done_change, done_timeout, done_coins
    );

    modport master (
        output req_valid, req_x_cnt, req_y_cnt, outz, outo,
        input  req_ready, inx, iny,
        input  done_valid, done_vend, done_change, done_timeout, done_coins
    );

endinterface

// File: rtl/vendor_customer_timer.sv
// Loadable down-counter shared by the coin gap and the vend timeout.
// Latency: zero_o is high in the last counted cycle (count will reach 0 at the next edge).
// Backpressure: none; load has priority over counting.
// Ports: clk, rst (async active-low), load_i/load_val_i load the count, zero_o flags expiry.
module vendor_customer_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // A load of L therefore yields exactly L cycles before the owner acts on expiry.
    assign zero_o = (cnt_q <= W'(1));

endmodule

// File: rtl/vendor_customer.sv
// Coin-insertion initiator: turns a (x, y) coin request into spaced inx/iny pulses and reports the vendor outcome.
// Latency: first coin 1 cycle after accept, coin period GAP+1, done at most N*(GAP+1)+TIMEOUT+1 cycles after accept.
// Backpressure: req_ready only in IDLE; done_valid is a one-cycle pulse that cannot be stalled.
// Ports: clk, rst (async active-low), bus (slave modport of vendor_customer_if).
// Optional: VENDOR_CUSTOMER_EARLY_STOP_EN skips the remaining coins once the vendor has dispensed.
module vendor_customer
    import vendor_pkg::*;
#(
    parameter int GAP     = 4,
    parameter int TIMEOUT = 16
) (
    input logic              clk,
    input logic              rst,
    vendor_customer_if.slave bus
);

    localparam int TW = $clog2(vc_max(GAP, TIMEOUT) + 1);

    vc_state_t  state_q, state_d;
    logic [2:0] x_left_q, x_left_d;
    logic [2:0] y_left_q, y_left_d;
    logic [3:0] coins_q, coins_d;
    logic       vend_q, vend_d;
    logic       change_q, change_d;
    logic       timeout_q, timeout_d;
    logic       inx_q, inx_d;
    logic       iny_q, iny_d;
    logic       done_valid_q, done_valid_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;

    logic       issue;
    logic [2:0] src_x;
    logic [2:0] src_y;
    logic       vend_now;
    logic       coins_left;
    logic       stop_early;

    vendor_customer_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        x_left_d     = x_left_q;
        y_left_d     = y_left_q;
        coins_d      = coins_q;
        vend_d       = vend_q;
        change_d     = change_q;
        timeout_d    = timeout_q;
        inx_d        = 1'b0;
        iny_d        = 1'b0;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        issue        = 1'b0;
        src_x        = x_left_q;
        src_y        = y_left_q;

        // Including this cycle's outz means a strobe landing on the final WAIT cycle wins over timeout.
        vend_now   = vend_q | bus.outz;
        coins_left = (x_left_q != 3'd0) || (y_left_q != 3'd0);
`ifdef VENDOR_CUSTOMER_EARLY_STOP_EN
        stop_early = vend_now;
`else
        stop_early = 1'b0;
`endif

        if (state_q inside {S_PULSE, S_GAP, S_WAIT}) begin
            vend_d   = vend_now;
            change_d = change_q | bus.outo;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    src_x     = bus.req_x_cnt;
                    src_y     = bus.req_y_cnt;
                    x_left_d  = bus.req_x_cnt;
                    y_left_d  = bus.req_y_cnt;
                    coins_d   = 4'd0;
                    vend_d    = 1'b0;
                    change_d  = 1'b0;
                    timeout_d = 1'b0;
                    if ((bus.req_x_cnt == 3'd0) && (bus.req_y_cnt == 3'd0)) begin
                        // Empty request takes a single settle cycle in GAP, then completes.
                        state_d  = S_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(1);
                    end else begin
                        state_d = S_PULSE;
                        issue   = 1'b1;
                    end
                end
            end
            S_PULSE: begin
                tmr_load = 1'b1;
                tmr_val  = TW'(GAP);
                state_d  = S_GAP;
            end
            S_GAP: begin
                if (stop_early) begin
                    state_d = S_DONE;
                end else if (tmr_zero) begin
                    if (coins_left) begin
                        state_d = S_PULSE;
                        issue   = 1'b1;
                    end else if (coins_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_WAIT;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(TIMEOUT);
                    end
                end
            end
            S_WAIT: begin
                if (vend_now) begin
                    state_d = S_DONE;
                end else if (tmr_zero) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Coin pulses are registered: the pulse is decided on the edge into PULSE so it is
        // high exactly for the PULSE cycle. All x coins drain before any y coin.
        if (issue) begin
            if (src_x != 3'd0) begin
                inx_d    = 1'b1;
                x_left_d = src_x - 3'd1;
                y_left_d = src_y;
            end else begin
                iny_d    = 1'b1;
                x_left_d = src_x;
                y_left_d = src_y - 3'd1;
            end
            coins_d = coins_d + 4'd1;
        end

        done_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            x_left_q     <= 3'd0;
            y_left_q     <= 3'd0;
            coins_q      <= 4'd0;
            vend_q       <= 1'b0;
            change_q     <= 1'b0;
            timeout_q    <= 1'b0;
            inx_q        <= 1'b0;
            iny_q        <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_left_q     <= x_left_d;
            y_left_q     <= y_left_d;
            coins_q      <= coins_d;
            vend_q       <= vend_d;
            change_q     <= change_d;
            timeout_q    <= timeout_d;
            inx_q        <= inx_d;
            iny_q        <= iny_d;
            done_valid_q <= done_valid_d;
        end
    end

    assign bus.req_ready    = (state_q == S_IDLE);
    assign bus.inx          = inx_q;
    assign bus.iny          = iny_q;
    assign bus.done_valid   = done_valid_q;
    assign bus.done_vend    = vend_q;
    assign bus.done_change  = change_q;
    assign bus.done_timeout = timeout_q;
    assign bus.done_coins   = coins_q;

endmodule
